// File: rtl/mips_bus_master.sv
// mips_bus_master: CPU load/store/fetch adapter onto an Avalon-style memory bus.
// Optional BUS_TIMEOUT_EN aborts a transaction after TIMEOUT_CYCLES stalled cycles.
module mips_bus_master #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] address,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t state, next;
    logic [1:0]  size_q, off_q;
    logic        signed_q, accept, illegal, done, timeout;
    logic [3:0]  be_d;
    logic [31:0] wd_d, shifted, ext;

    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
    assign accept     = req_valid && req_ready;
    assign done       = state == BUS && (!waitrequest || timeout);

`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else if (accept) cnt <= '0;
        else if (state == BUS && waitrequest) cnt <= cnt + 1'b1;
    end
    assign timeout = state == BUS && waitrequest && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    wire [31:0] unused_timeout = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        illegal = req_size == 2'd3 || (req_size == 2'd1 && req_addr[0]) ||
                  (req_size == 2'd2 && req_addr[1:0] != 2'b00);
        be_d = req_size == 2'd0 ? 4'b0001 << req_addr[1:0] :
               req_size == 2'd1 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd_d = req_size == 2'd0 ? {4{req_wdata[7:0]}} :
               req_size == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
        // Shifting by the saved byte offset right-justifies either a byte or a halfword
        shifted = readdata >> {off_q, 3'b000};
        ext = size_q == 2'd0 ? {{24{signed_q & shifted[7]}}, shifted[7:0]} :
              size_q == 2'd1 ? {{16{signed_q & shifted[15]}}, shifted[15:0]} : readdata;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE: next = accept ? (illegal ? RESP : BUS) : IDLE;
            BUS:  next = done ? RESP : BUS;
            RESP: next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            address    <= '0;
            byteenable <= '0;
            writedata  <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            size_q     <= '0;
            off_q      <= '0;
            signed_q   <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept && !illegal) begin
                address    <= {req_addr[31:2], 2'b00};
                byteenable <= be_d;
                writedata  <= wd_d;
                read       <= !req_write;
                write      <= req_write;
                size_q     <= req_size;
                off_q      <= req_addr[1:0];
                signed_q   <= req_signed;
            end
            if (accept && illegal) begin
                resp_err   <= 1'b1;
                resp_rdata <= '0;
            end
            if (done) begin
                read       <= 1'b0;
                write      <= 1'b0;
                resp_err   <= timeout;
                resp_rdata <= (read && !timeout) ? ext : '0;
            end
        end
    end
endmodule

// File: tb/tb_mips_bus_master.sv
// tb_mips_bus_master: table-driven directed checks of mips_bus_master plus reset/timeout sequences.
module tb_mips_bus_master;
    logic        clk = 0, reset_n = 0;
    logic        req_valid = 0, req_ready, req_write = 0, req_signed = 0;
    logic [31:0] req_addr = 0, req_wdata = 0, resp_rdata, address, writedata, readdata = 0;
    logic [1:0]  req_size = 0;
    logic        resp_valid, resp_err, write, read, waitrequest = 0;
    logic [3:0]  byteenable;
    int checks = 0, errors = 0;

    mips_bus_master #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .address(address),
        .byteenable(byteenable), .writedata(writedata), .write(write), .read(read),
        .waitrequest(waitrequest), .readdata(readdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic        bus;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input int id, input vec_t v);
        string n = $sformatf("v%0d", id);
        @(negedge clk);
        chk({n, " ready"}, 32'(req_ready), 1);
        req_valid = 1; req_addr = v.addr; req_write = v.wr; req_size = v.size;
        req_signed = v.sgn; req_wdata = v.wdata; readdata = v.rdata;
        @(negedge clk);
        req_valid = 0;
        if (v.bus) begin
            for (int i = 0; i <= v.waits; i++) begin
                waitrequest = i < v.waits;
                chk({n, " read"}, 32'(read), 32'(!v.wr));
                chk({n, " write"}, 32'(write), 32'(v.wr));
                chk({n, " address"}, address, v.exp_addr);
                chk({n, " byteenable"}, 32'(byteenable), 32'(v.exp_be));
                chk({n, " writedata"}, writedata, v.exp_wdata);
                chk({n, " early resp"}, 32'(resp_valid), 0);
                @(negedge clk);
            end
            waitrequest = 0;
        end
        chk({n, " strobes off"}, {30'd0, read, write}, 0);
        chk({n, " resp_valid"}, 32'(resp_valid), 1);
        chk({n, " resp_err"}, 32'(resp_err), 32'(v.exp_err));
        chk({n, " resp_rdata"}, resp_rdata, v.exp_rdata);
        @(negedge clk);
        chk({n, " resp pulse"}, 32'(resp_valid), 0);
        chk({n, " rdata held"}, resp_rdata, v.exp_rdata);
    endtask

    initial begin
        //           addr          wr sz sg wdata         rdata         w  bus exp_addr      be       exp_wdata     exp_rdata     err
        vecs[0]  = '{32'hBFC00004, 0, 2, 0, 32'h0,        32'h12345678, 0, 1, 32'hBFC00004, 4'b1111, 32'h0,        32'h12345678, 0};
        vecs[1]  = '{32'hBFC00003, 0, 0, 1, 32'h0,        32'h80FF0011, 0, 1, 32'hBFC00000, 4'b1000, 32'h0,        32'hFFFFFF80, 0};
        vecs[2]  = '{32'hBFC00003, 0, 0, 0, 32'h0,        32'h80FF0011, 0, 1, 32'hBFC00000, 4'b1000, 32'h0,        32'h00000080, 0};
        vecs[3]  = '{32'h00000102, 0, 1, 1, 32'h0,        32'h80FF0011, 0, 1, 32'h00000100, 4'b1100, 32'h0,        32'hFFFF80FF, 0};
        vecs[4]  = '{32'h00000100, 0, 1, 1, 32'h0,        32'h80FF0011, 0, 1, 32'h00000100, 4'b0011, 32'h0,        32'h00000011, 0};
        vecs[5]  = '{32'h00000202, 0, 0, 1, 32'h0,        32'h80FF0011, 1, 1, 32'h00000200, 4'b0100, 32'h0,        32'hFFFFFFFF, 0};
        vecs[6]  = '{32'h00000301, 1, 0, 0, 32'h000000A5, 32'h0,        0, 1, 32'h00000300, 4'b0010, 32'hA5A5A5A5, 32'h0,        0};
        vecs[7]  = '{32'h00000400, 1, 2, 0, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 1, 32'h00000400, 4'b1111, 32'hDEADBEEF, 32'h0,        0};
        vecs[8]  = '{32'h00001002, 1, 1, 0, 32'h0000BEEF, 32'h0,        3, 1, 32'h00001000, 4'b1100, 32'hBEEFBEEF, 32'h0,        0};
        vecs[9]  = '{32'h00000002, 0, 2, 0, 32'h0,        32'h12345678, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1};
        vecs[10] = '{32'h00000000, 0, 3, 0, 32'h0,        32'h12345678, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1};
        vecs[11] = '{32'h00000001, 0, 1, 1, 32'h0,        32'h12345678, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1};

        #12;
        chk("reset outputs", {28'd0, read, write, resp_valid, resp_err}, 0);
        chk("reset address", address, 0);
        chk("reset byteenable", 32'(byteenable), 0);
        chk("reset writedata", writedata, 0);
        chk("reset resp_rdata", resp_rdata, 0);
        chk("reset ready", 32'(req_ready), 1);
        @(negedge clk);
        reset_n = 1;

        for (int i = 0; i < 12; i++) run(i, vecs[i]);

        // Reset in the middle of a stalled read abandons it with no response
        @(negedge clk);
        req_valid = 1; req_addr = 32'h10; req_write = 0; req_size = 2; waitrequest = 1;
        @(negedge clk);
        req_valid = 0;
        chk("rst-bus read", 32'(read), 1);
        #2 reset_n = 0;
        #1;
        chk("rst-bus async read", 32'(read), 0);
        chk("rst-bus resp", 32'(resp_valid), 0);
        @(negedge clk);
        reset_n = 1; waitrequest = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst-bus no resp", 32'(resp_valid), 0);
            chk("rst-bus ready", 32'(req_ready), 1);
        end
        run(100, vecs[0]);

`ifdef BUS_TIMEOUT_EN
        @(negedge clk);
        req_valid = 1; req_addr = 32'h20; req_write = 0; req_size = 2; waitrequest = 1;
        @(negedge clk);
        req_valid = 0;
        for (int i = 0; i < 4; i++) begin
            chk("timeout read held", 32'(read), 1);
            chk("timeout no resp", 32'(resp_valid), 0);
            @(negedge clk);
        end
        chk("timeout read dropped", 32'(read), 0);
        chk("timeout resp_valid", 32'(resp_valid), 1);
        chk("timeout resp_err", 32'(resp_err), 1);
        chk("timeout resp_rdata", resp_rdata, 0);
        waitrequest = 0;
        @(negedge clk);
        chk("timeout idle", 32'(req_ready), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_bus_master.md
Name: mips_bus_master

Overview:
- CPU-side load/store/fetch adapter driving the Avalon-style memory bus (address, byteenable, writedata, read, write, waitrequest, readdata).
- Sits directly upstream of the bus memory. Accepts one sized request at a time from the CPU core and converts it into a word-aligned bus transaction with lane byteenables.
- Returns sign- or zero-extended read data and flags misaligned or illegal requests without issuing a bus cycle.

Parameters:
- TIMEOUT_CYCLES, 256, waitrequest-high cycles before abort (only with BUS_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
- req_addr  in  32  byte address
- req_write  in  1  1 = store, 0 = load/fetch
- req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal
- req_signed  in  1  sign-extend loaded byte/halfword
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid: misaligned, illegal size or timeout
- address  out  32  bus word address, {req_addr[31:2],2'b00}
- byteenable  out  4  lane enables
- writedata  out  32  lane-replicated store data
- write  out  1  bus write strobe
- read  out  1  bus read strobe
- waitrequest  in  1  slave stall
- readdata  in  32  slave read data

Behaviour:
- Reset (async, reset_n=0): state IDLE; read=0, write=0, address=0, byteenable=0, writedata=0, resp_valid=0, resp_rdata=0, resp_err=0. req_ready=1 once in IDLE. A reset during BUS drops the strobes immediately and abandons the transaction; no response is produced.
- States: IDLE, BUS, RESP.
- IDLE, on accept, classifies the request:
  - Illegal if req_size=3, halfword with addr[0]=1, or word with addr[1:0]!=0. Illegal requests go to RESP with err=1 and no bus strobe.
  - Otherwise: register address, byteenable, writedata, size, signed and addr[1:0]; assert read or write on the next cycle (registered outputs); go to BUS.
- byteenable (lane k = readdata/writedata[8k+7:8k]):
  - byte: 4'b0001<<addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- writedata:
  - byte: replicated to all 4 lanes
  - half: replicated to both halves
  - word: as-is
- BUS: all bus outputs are held stable while waitrequest=1. In the first cycle with waitrequest=0:
  - Strobes deassert next cycle.
  - For reads, capture readdata in that same cycle, select the lane(s) by the saved addr[1:0], extend per req_signed, and load resp_rdata.
  - Go to RESP.
- RESP: resp_valid=1 for exactly one cycle, with resp_err and resp_rdata held; then return to IDLE with resp_valid=0. resp_rdata holds its value until the next response.
- Minimum latency with no waitrequest: accept at edge N, strobe during cycle N+1, resp_valid during cycle N+2. Each waitrequest cycle adds one.
- Back-to-back: a new request is accepted in the cycle after RESP. There is no overlap and no pipelining.
- Store completion returns resp_rdata=0, resp_err=0.

Optional Feature:
- BUS_TIMEOUT_EN:
  - Defined: a counter increments each BUS cycle with waitrequest=1 and is cleared on entry to BUS. When it reaches TIMEOUT_CYCLES, strobes drop and the block goes to RESP with resp_err=1 and resp_rdata=0.
  - Undefined: no counter; BUS waits indefinitely.

Test Plan:
- Word load at 0xBFC00004, readdata=0x12345678, waitrequest=0 → address=0xBFC00004, byteenable=4'b1111, read held 1 cycle, resp_valid 2 cycles after accept, resp_rdata=0x12345678, err=0.
- Signed byte load at 0xBFC00003, readdata=0x80FF0011 → byteenable=4'b1000, resp_rdata=0xFFFFFF80; same request unsigned → 0x00000080.
- Halfword store at 0x00001002 with wdata=0x0000BEEF, waitrequest high 3 cycles → write, address=0x00001000, byteenable=4'b1100 and writedata=0xBEEFBEEF stable for all 4 cycles; resp_valid 1 cycle after release.
- Word load at 0x00000002, and a request with req_size=3 → no read/write strobe, resp_valid with resp_err=1, resp_rdata=0.
- reset_n pulled low during BUS with waitrequest=1 → read=0 asynchronously, no resp_valid, req_ready=1 after release; next request completes normally.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, waitrequest stuck high → read drops after 4 stall cycles, resp_valid with resp_err=1.
